// File: rtl/clk_rst_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_rst_monitor
// Description : Watches a derived clock (clk_mon) and its active-low reset
//               (rst_n_mon) from the clk_in domain. It measures the clk_mon
//               period, declares lock after a run of in-tolerance periods,
//               and latches a sticky fault on a stuck clock, a frequency
//               error or a reset that never deasserts.
// Ports       : clk_in       - monitor clock
//               rst_in       - asynchronous active-high reset
//               clk_mon      - monitored clock (asynchronous)
//               rst_n_mon    - monitored active-low reset (asynchronous)
//               clear_fault  - single-cycle request to clear a latched fault
//               locked       - monitored clock is in tolerance
//               fault        - sticky fault flag
//               fault_code   - 01 reset timeout, 10 stuck clock, 11 freq error
//               period_meas  - last measured clk_mon period (clk_in cycles)
//               rst_latency  - cycles from RESET_WAIT entry to rst_n_mon high
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_monitor #(
   parameter int EXP_PERIOD  = 2,
   parameter int TOL         = 0,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 16,
   parameter int RST_TIMEOUT = 32
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        clk_mon,
   input  logic        rst_n_mon,
   input  logic        clear_fault,
   output logic        locked,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [15:0] period_meas,
   output logic [15:0] rst_latency
);

   typedef enum logic [1:0] {
      RESET_WAIT = 2'd0,
      MEASURE    = 2'd1,
      LOCKED     = 2'd2,
      FAULT      = 2'd3
   } state_t;

   localparam logic [1:0]  c_code_none  = 2'b00;
   localparam logic [1:0]  c_code_rst   = 2'b01;
   localparam logic [1:0]  c_code_stuck = 2'b10;
   localparam logic [1:0]  c_code_freq  = 2'b11;
   localparam logic [15:0] c_cnt_max    = 16'hFFFF;

   // Acceptance window for a measured period; the lower bound is clamped at
   // zero so a tolerance wider than the nominal period cannot wrap.
   localparam logic [31:0] c_per_lo = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
   localparam logic [31:0] c_per_hi = EXP_PERIOD + TOL;

   // Thresholds compared against the pre-increment counter value, so an
   // event fires on the cycle the count would reach its limit.
   localparam logic [15:0] c_lock_last = 16'(LOCK_COUNT - 1);
   localparam logic [15:0] c_idle_last = 16'(TIMEOUT - 1);
   localparam logic [15:0] c_lat_last  = 16'(RST_TIMEOUT - 1);

   state_t      state_q, state_d;

   logic        clk_meta_q, clk_meta_d;
   logic        clk_sync_q, clk_sync_d;
   logic        clk_prev_q, clk_prev_d;
   logic        rstn_meta_q, rstn_meta_d;
   logic        rstn_sync_q, rstn_sync_d;

   logic [15:0] period_cnt_q, period_cnt_d;
   logic [15:0] lat_cnt_q, lat_cnt_d;
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic [15:0] good_cnt_q, good_cnt_d;
   logic        first_seen_q, first_seen_d;

   logic        locked_q, locked_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic [15:0] period_meas_q, period_meas_d;
   logic [15:0] rst_latency_q, rst_latency_d;

   logic        mon_edge;
   logic        period_in_tol;
   logic        idle_expired;

   assign mon_edge      = clk_sync_q & ~clk_prev_q;
   assign period_in_tol = ({16'd0, period_cnt_q} >= c_per_lo) &&
                          ({16'd0, period_cnt_q} <= c_per_hi);
   // A stuck clock is only declared on a cycle without an edge, so a
   // timeout and a frequency check can never land on the same cycle.
   assign idle_expired  = !mon_edge && (idle_cnt_q >= c_idle_last);

   assign locked      = locked_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign period_meas = period_meas_q;
   assign rst_latency = rst_latency_q;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= RESET_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Synchronizers, counters and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         clk_meta_q    <= 1'b0;
         clk_sync_q    <= 1'b0;
         clk_prev_q    <= 1'b0;
         rstn_meta_q   <= 1'b0;
         rstn_sync_q   <= 1'b0;
         period_cnt_q  <= 16'd0;
         lat_cnt_q     <= 16'd0;
         idle_cnt_q    <= 16'd0;
         good_cnt_q    <= 16'd0;
         first_seen_q  <= 1'b0;
         locked_q      <= 1'b0;
         fault_q       <= 1'b0;
         fault_code_q  <= c_code_none;
         period_meas_q <= 16'd0;
         rst_latency_q <= 16'd0;
      end else begin
         clk_meta_q    <= clk_meta_d;
         clk_sync_q    <= clk_sync_d;
         clk_prev_q    <= clk_prev_d;
         rstn_meta_q   <= rstn_meta_d;
         rstn_sync_q   <= rstn_sync_d;
         period_cnt_q  <= period_cnt_d;
         lat_cnt_q     <= lat_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         good_cnt_q    <= good_cnt_d;
         first_seen_q  <= first_seen_d;
         locked_q      <= locked_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         period_meas_q <= period_meas_d;
         rst_latency_q <= rst_latency_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      clk_meta_d    = clk_mon;
      clk_sync_d    = clk_meta_q;
      clk_prev_d    = clk_sync_q;
      rstn_meta_d   = rst_n_mon;
      rstn_sync_d   = rstn_meta_q;

      state_d       = state_q;
      lat_cnt_d     = lat_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      good_cnt_d    = good_cnt_q;
      first_seen_d  = first_seen_q;
      locked_d      = locked_q;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      period_meas_d = period_meas_q;
      rst_latency_d = rst_latency_q;

      // Free-running period counter; edges are not acted on while waiting
      // for the monitored reset, so period_meas holds there.
      period_cnt_d = (period_cnt_q == c_cnt_max) ? c_cnt_max : period_cnt_q + 16'd1;
      if (mon_edge && (state_q != RESET_WAIT)) begin
         period_meas_d = period_cnt_q;
         period_cnt_d  = 16'd1;
      end

      case (state_q)
         RESET_WAIT: begin
            if (rstn_sync_q) begin
               rst_latency_d = lat_cnt_q;
               good_cnt_d    = 16'd0;
               first_seen_d  = 1'b0;
               idle_cnt_d    = 16'd0;
               state_d       = MEASURE;
            end else if (lat_cnt_q >= c_lat_last) begin
               fault_d       = 1'b1;
               fault_code_d  = c_code_rst;
               state_d       = FAULT;
            end else begin
               lat_cnt_d     = lat_cnt_q + 16'd1;
            end
         end

         MEASURE: begin
            if (!rstn_sync_q) begin
               lat_cnt_d     = 16'd0;
               good_cnt_d    = 16'd0;
               locked_d      = 1'b0;
               state_d       = RESET_WAIT;
            end else if (idle_expired) begin
               fault_d       = 1'b1;
               fault_code_d  = c_code_stuck;
               locked_d      = 1'b0;
               state_d       = FAULT;
            end else if (mon_edge) begin
               idle_cnt_d    = 16'd0;
               if (!first_seen_q) begin
                  // Counter was free-running before this edge: no valid period.
                  first_seen_d = 1'b1;
               end else if (period_in_tol) begin
                  good_cnt_d = good_cnt_q + 16'd1;
                  if (good_cnt_q >= c_lock_last) begin
                     locked_d = 1'b1;
                     state_d  = LOCKED;
                  end
               end else begin
                  good_cnt_d = 16'd0;
               end
            end else begin
               idle_cnt_d    = idle_cnt_q + 16'd1;
            end
         end

         LOCKED: begin
            if (!rstn_sync_q) begin
               lat_cnt_d     = 16'd0;
               good_cnt_d    = 16'd0;
               locked_d      = 1'b0;
               state_d       = RESET_WAIT;
            end else if (idle_expired) begin
               fault_d       = 1'b1;
               fault_code_d  = c_code_stuck;
               locked_d      = 1'b0;
               state_d       = FAULT;
            end else if (mon_edge) begin
               idle_cnt_d    = 16'd0;
               if (!period_in_tol) begin
                  fault_d      = 1'b1;
                  fault_code_d = c_code_freq;
                  locked_d     = 1'b0;
                  state_d      = FAULT;
               end
            end else begin
               idle_cnt_d    = idle_cnt_q + 16'd1;
            end
         end

         FAULT: begin
            // Fault conditions are ignored here; only a clear leaves.
            if (clear_fault) begin
               fault_d       = 1'b0;
               fault_code_d  = c_code_none;
               lat_cnt_d     = 16'd0;
               good_cnt_d    = 16'd0;
               state_d       = RESET_WAIT;
            end
         end

         default: begin
            state_d = RESET_WAIT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_clk_rst_monitor
// Description : Self-checking bench for clk_rst_monitor. Directed scenarios
//               followed by randomized clock/reset activity, all compared
//               cycle by cycle against a time-stamp based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_monitor;

   localparam int EXP_PERIOD  = 2;
   localparam int TOL         = 0;
   localparam int LOCK_COUNT  = 4;
   localparam int TIMEOUT     = 16;
   localparam int RST_TIMEOUT = 32;

   localparam int M_WAIT  = 0;
   localparam int M_MEAS  = 1;
   localparam int M_LOCK  = 2;
   localparam int M_FAULT = 3;

   logic        clk_in      = 1'b0;
   logic        rst_in      = 1'b1;
   logic        clk_mon     = 1'b0;
   logic        rst_n_mon   = 1'b0;
   logic        clear_fault = 1'b0;
   logic        locked;
   logic        fault;
   logic [1:0]  fault_code;
   logic [15:0] period_meas;
   logic [15:0] rst_latency;

   int n_asserts = 0;
   int n_fail    = 0;

   // clk_mon generator: toggles every 'half' clk_in cycles while cm_run
   bit cm;
   bit cm_run;
   int half;
   int ph;

   // reference model: cycle stamps instead of counters
   int m_cyc;
   int m_mode;
   int m_wait_start;   // first cycle spent waiting for rst_n_mon
   int m_reload;       // cycle of the last period restart
   int m_watch;        // cycle of last edge (or MEASURE entry) for stuck check
   int m_good;
   bit m_first;
   bit h_cm [3];       // [0]=one cycle ago, [1]=two, [2]=three
   bit h_rn [3];
   int e_locked, e_fault, e_code, e_pmeas, e_lat;

   int rise;
   int gap;
   int rn_low;
   bit rnv;
   bit cfv;
   bit seen;

   clk_rst_monitor #(
      .EXP_PERIOD  (EXP_PERIOD),
      .TOL         (TOL),
      .LOCK_COUNT  (LOCK_COUNT),
      .TIMEOUT     (TIMEOUT),
      .RST_TIMEOUT (RST_TIMEOUT)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clk_mon     (clk_mon),
      .rst_n_mon   (rst_n_mon),
      .clear_fault (clear_fault),
      .locked      (locked),
      .fault       (fault),
      .fault_code  (fault_code),
      .period_meas (period_meas),
      .rst_latency (rst_latency)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string pre);
      chk({pre, "_locked"}, 32'(locked), 0);
      chk({pre, "_fault"},  32'(fault), 0);
      chk({pre, "_code"},   32'(fault_code), 0);
      chk({pre, "_pmeas"},  32'(period_meas), 0);
      chk({pre, "_lat"},    32'(rst_latency), 0);
   endtask

   task automatic model_reset();
      m_cyc = 0; m_mode = M_WAIT; m_wait_start = 1; m_reload = 1;
      m_watch = 0; m_good = 0; m_first = 1'b0;
      for (int i = 0; i < 3; i++) begin h_cm[i] = 1'b0; h_rn[i] = 1'b0; end
      e_locked = 0; e_fault = 0; e_code = 0; e_pmeas = 0; e_lat = 0;
   endtask

   // One clk_in rising edge; inputs are those sampled at this edge.
   task automatic model_tick(input bit cmv, input bit rnv_i, input bit cfv_i);
      bit s_cm, p_cm, s_rn, edge_det;
      int per, dev, old_mode;
      m_cyc++;
      s_cm     = h_cm[1];
      p_cm     = h_cm[2];
      s_rn     = h_rn[1];
      edge_det = s_cm && !p_cm;
      per      = m_cyc - m_reload;
      if (per > 65535) per = 65535;
      dev      = (per > EXP_PERIOD) ? per - EXP_PERIOD : EXP_PERIOD - per;
      old_mode = m_mode;
      case (old_mode)
         M_WAIT: begin
            if (s_rn) begin
               e_lat = m_cyc - m_wait_start;
               m_good = 0; m_first = 1'b0; m_watch = m_cyc; m_mode = M_MEAS;
            end else if (m_cyc - m_wait_start + 1 >= RST_TIMEOUT) begin
               m_mode = M_FAULT; e_fault = 1; e_code = 1;
            end
         end
         M_MEAS, M_LOCK: begin
            if (!s_rn) begin
               m_mode = M_WAIT; m_wait_start = m_cyc + 1; e_locked = 0;
            end else if (!edge_det && (m_cyc - m_watch >= TIMEOUT)) begin
               m_mode = M_FAULT; e_fault = 1; e_code = 2; e_locked = 0;
            end else if (edge_det) begin
               m_watch = m_cyc;
               if (old_mode == M_MEAS) begin
                  if (!m_first) m_first = 1'b1;
                  else if (dev <= TOL) begin
                     m_good++;
                     if (m_good >= LOCK_COUNT) begin m_mode = M_LOCK; e_locked = 1; end
                  end else m_good = 0;
               end else if (dev > TOL) begin
                  m_mode = M_FAULT; e_fault = 1; e_code = 3; e_locked = 0;
               end
            end
         end
         default: begin
            if (cfv_i) begin
               m_mode = M_WAIT; m_wait_start = m_cyc + 1; e_fault = 0; e_code = 0;
            end
         end
      endcase
      if (edge_det && old_mode != M_WAIT) begin
         e_pmeas = per; m_reload = m_cyc;
      end
      h_cm[2] = h_cm[1]; h_cm[1] = h_cm[0]; h_cm[0] = cmv;
      h_rn[2] = h_rn[1]; h_rn[1] = h_rn[0]; h_rn[0] = rnv_i;
   endtask

   // Called at a falling edge: drive, let the rising edge happen, compare.
   task automatic step(input bit rn_i, input bit cf_i);
      if (cm_run) begin
         ph++;
         if (ph >= half) begin ph = 0; cm = !cm; end
      end
      clk_mon = cm; rst_n_mon = rn_i; clear_fault = cf_i;
      @(posedge clk_in);
      model_tick(cm, rn_i, cf_i);
      #1;
      chk("locked", 32'(locked), e_locked);
      chk("fault", 32'(fault), e_fault);
      chk("fault_code", 32'(fault_code), e_code);
      chk("period_meas", 32'(period_meas), e_pmeas);
      chk("rst_latency", 32'(rst_latency), e_lat);
      @(negedge clk_in);
   endtask

   task automatic do_reset();
      rst_in = 1'b1; clk_mon = 1'b0; rst_n_mon = 1'b0; clear_fault = 1'b0;
      #1;
      chk_zero("rst_async");
      repeat (3) @(negedge clk_in);
      chk_zero("rst_hold");
      model_reset();
      cm = 1'b0; ph = 0;
      rst_in = 1'b0;
   endtask

   initial begin
      @(negedge clk_in);
      do_reset();

      // Nominal bring-up: period 2, rst_n_mon high from the 4th cycle
      cm_run = 1'b1; half = 1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
      chk("bringup_latency", 32'(rst_latency), 5);
      chk("bringup_period", 32'(period_meas), 2);
      chk("bringup_locked", 32'(locked), 1);
      chk("bringup_fault", 32'(fault), 0);

      // Stuck-low clock while locked
      cm_run = 1'b0; cm = 1'b0; rise = -1; gap = -1;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b0);
         if (fault === 1'b1 && rise < 0) begin rise = m_cyc; gap = m_cyc - m_watch; end
      end
      chk("stuck_seen", 32'(rise >= 0), 1);
      chk("stuck_gap", gap, 16);
      chk("stuck_code", 32'(fault_code), 2);
      chk("stuck_locked", 32'(locked), 0);

      // Clear while the stuck condition is still present, then relock
      step(1'b1, 1'b1);
      chk("clear_fault", 32'(fault), 0);
      chk("clear_code", 32'(fault_code), 0);
      cm_run = 1'b1; half = 1; ph = 0;
      for (int i = 0; i < 24; i++) step(1'b1, 1'b0);
      chk("relock1", 32'(locked), 1);

      // Period changes to 4 while locked
      if (cm == 1'b0) step(1'b1, 1'b0);
      half = 2; ph = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         if (fault === 1'b1 && !seen) begin
            seen = 1'b1;
            chk("freq_code", 32'(fault_code), 3);
            chk("freq_period", 32'(period_meas), 4);
         end
      end
      chk("freq_seen", 32'(seen), 1);

      // Clear and relock at period 2
      step(1'b1, 1'b1);
      half = 1; ph = 0;
      for (int i = 0; i < 24; i++) step(1'b1, 1'b0);
      chk("relock2", 32'(locked), 1);

      // Monitored reset pulsed low for 4 cycles
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      chk("rstn_pulse_locked", 32'(locked), 0);
      chk("rstn_pulse_fault", 32'(fault), 0);
      for (int i = 0; i < 24; i++) step(1'b1, 1'b0);
      chk("relock3", 32'(locked), 1);

      // rst_in asserted while locked: outputs clear immediately
      do_reset();

      // rst_n_mon never deasserts
      cm_run = 1'b1; half = 1; rise = -1;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0);
         if (fault === 1'b1 && rise < 0) rise = m_cyc;
      end
      chk("rst_to_cycle", rise, 32);
      chk("rst_to_code", 32'(fault_code), 1);
      chk("rst_to_latency", 32'(rst_latency), 0);

      // Randomized activity
      do_reset();
      cm_run = 1'b1; half = 1; rn_low = 0;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 39) == 0)
            half = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 1;
         if (rn_low == 0 && $urandom_range(0, 79) == 0)
            rn_low = int'($urandom_range(1, 6));
         rnv = (rn_low == 0);
         if (rn_low > 0) rn_low--;
         cfv = ($urandom_range(0, 15) == 0);
         step(rnv, cfv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
